// File: rtl/instr_fetch.sv
// Instruction fetch: one request/ack transaction per instruction, then a valid/ready
// hand-off to decode; flushes abandon or drain the in-flight fetch.
module instr_fetch #(
    parameter logic [31:0] NOP = 32'h00000013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_pc,
    output logic        o_pc_adv,
    input  logic        i_flush,
    output logic        o_mem_req,
    output logic [13:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [15:0] o_inst_pc,
    output logic        o_inst_fault
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [13:0] r_mem_addr;
    logic [31:0] r_inst;
    logic [15:0] r_inst_pc;
    logic        r_inst_fault;
    logic        w_misaligned;
    logic        w_capture;
    logic        w_pc_adv;
    logic        w_mem_req;

    assign w_misaligned = |i_pc[1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_pc_adv    = 1'b0;
        w_mem_req   = 1'b0;
        case (r_state)
            IDLE: w_state_nxt = REQ;
            REQ: begin
                if (w_misaligned) begin
                    // Nothing issued, so a flush simply retries with the new pc.
                    if (!i_flush) begin
                        w_capture   = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end else begin
                    w_mem_req = 1'b1;
                    if (i_mem_ack && !i_flush) begin
                        w_capture   = 1'b1;
                        w_state_nxt = HOLD;
                    end else if (!i_mem_ack && i_flush) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            HOLD: begin
                if (i_flush) begin
                    w_state_nxt = REQ;
                end else if (i_inst_ready) begin
                    w_pc_adv    = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            DRAIN: begin
                w_mem_req = 1'b1;
                if (i_mem_ack) w_state_nxt = REQ;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_mem_addr   <= 14'd0;
            r_inst       <= NOP;
            r_inst_pc    <= 16'd0;
            r_inst_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == REQ) r_mem_addr <= i_pc[15:2];
            if (w_capture) begin
                r_inst       <= w_misaligned ? NOP : i_mem_rdata;
                r_inst_pc    <= i_pc;
                r_inst_fault <= w_misaligned;
            end
        end
    end

    // The PC register only settles on the REQ entry edge, so the first REQ cycle
    // drives the live pc; the register keeps that word for DRAIN after a redirect.
    assign o_mem_addr   = (r_state == REQ) ? i_pc[15:2] : r_mem_addr;
    assign o_mem_req    = w_mem_req;
    assign o_pc_adv     = w_pc_adv;
    assign o_inst_valid = (r_state == HOLD);
    assign o_inst       = r_inst;
    assign o_inst_pc    = r_inst_pc;
    assign o_inst_fault = r_inst_fault;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: the bench plays both the PC register and the
// instruction memory, with hand-computed expectations at each step.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic        pc_adv;
    logic        flush;
    logic        mem_req;
    logic [13:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [15:0] inst_pc;
    logic        inst_fault;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_fetch #(.NOP(NOP)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_pc         (pc),
        .o_pc_adv     (pc_adv),
        .i_flush      (flush),
        .o_mem_req    (mem_req),
        .o_mem_addr   (mem_addr),
        .i_mem_ack    (mem_ack),
        .i_mem_rdata  (mem_rdata),
        .o_inst_valid (inst_valid),
        .i_inst_ready (inst_ready),
        .o_inst       (inst),
        .o_inst_pc    (inst_pc),
        .o_inst_fault (inst_fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; pc = 16'd0; flush = 1'b0; mem_ack = 1'b0;
        mem_rdata = 32'd0; inst_ready = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            step();
            pc = 16'($urandom); flush = 1'($urandom); mem_ack = 1'($urandom);
            mem_rdata = $urandom; inst_ready = 1'($urandom);
            settle();
            check("rst_mem_req", mem_req, 0);
            check("rst_inst_valid", inst_valid, 0);
            check("rst_pc_adv", pc_adv, 0);
            check("rst_inst", inst, NOP);
        end
        check("rst_inst_pc", inst_pc, 0);
        check("rst_fault", inst_fault, 0);
        check("rst_mem_addr", mem_addr, 0);

        rst = 1'b0; pc = 16'h0000; flush = 1'b0; mem_ack = 1'b0; inst_ready = 1'b1;
        settle();
        check("idle_no_req", mem_req, 0);
        step();
        check("first_req", mem_req, 1);
        check("first_addr", mem_addr, 14'h0000);

        // Zero-wait stream pc 0,4,8
        mem_ack = 1'b1; mem_rdata = 32'h1111_0001;
        settle();
        check("zw0_pc_adv_req", pc_adv, 0);
        step();
        mem_ack = 1'b0;
        settle();
        check("zw0_valid", inst_valid, 1);
        check("zw0_inst", inst, 32'h1111_0001);
        check("zw0_inst_pc", inst_pc, 16'h0000);
        check("zw0_pc_adv", pc_adv, 1);
        step();
        pc = 16'h0004; mem_ack = 1'b1; mem_rdata = 32'h2222_0002;
        settle();
        check("zw1_req", mem_req, 1);
        check("zw1_addr", mem_addr, 14'h0001);
        check("zw1_pc_adv_req", pc_adv, 0);
        check("zw1_not_valid", inst_valid, 0);
        step();
        mem_ack = 1'b0;
        settle();
        check("zw1_inst", inst, 32'h2222_0002);
        check("zw1_inst_pc", inst_pc, 16'h0004);
        check("zw1_pc_adv", pc_adv, 1);
        step();
        pc = 16'h0008; mem_ack = 1'b1; mem_rdata = 32'h3333_0003;
        settle();
        check("zw2_addr", mem_addr, 14'h0002);
        check("zw2_pc_adv_req", pc_adv, 0);
        step();
        mem_ack = 1'b0;
        settle();
        check("zw2_inst", inst, 32'h3333_0003);
        check("zw2_inst_pc", inst_pc, 16'h0008);
        check("zw2_pc_adv", pc_adv, 1);
        step();

        // Wait states (ack 3 cycles after request) with backpressure
        pc = 16'h000C; inst_ready = 1'b0; mem_ack = 1'b0;
        settle();
        for (int i = 0; i < 3; i++) begin
            check("ws_req", mem_req, 1);
            check("ws_addr", mem_addr, 14'h0003);
            check("ws_not_valid", inst_valid, 0);
            step();
        end
        mem_ack = 1'b1; mem_rdata = 32'h4444_0004;
        settle();
        check("ws_ack_addr", mem_addr, 14'h0003);
        step();
        mem_ack = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("bp_valid", inst_valid, 1);
            check("bp_inst", inst, 32'h4444_0004);
            check("bp_pc_adv", pc_adv, 0);
            step();
        end
        inst_ready = 1'b1;
        settle();
        check("bp_inst_pc", inst_pc, 16'h000C);
        check("bp_release_pc_adv", pc_adv, 1);
        step();

        // Flush while a request is pending -> DRAIN
        pc = 16'h0010;
        settle();
        check("dr_req", mem_req, 1);
        check("dr_addr", mem_addr, 14'h0004);
        step();
        flush = 1'b1;
        settle();
        check("dr_flush_pc_adv", pc_adv, 0);
        step();
        flush = 1'b0; pc = 16'h0100;
        settle();
        check("dr_hold_req", mem_req, 1);
        check("dr_old_addr", mem_addr, 14'h0004);
        check("dr_not_valid", inst_valid, 0);
        step();
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        settle();
        check("dr_ack_addr", mem_addr, 14'h0004);
        check("dr_ack_not_valid", inst_valid, 0);
        step();
        mem_ack = 1'b0;
        settle();
        check("dr_discard_valid", inst_valid, 0);
        check("dr_new_req", mem_req, 1);
        check("dr_new_addr", mem_addr, 14'h0040);
        mem_ack = 1'b1; mem_rdata = 32'h5555_0005;
        step();
        mem_ack = 1'b0;
        settle();
        check("dr_after_valid", inst_valid, 1);
        check("dr_after_inst", inst, 32'h5555_0005);
        check("dr_after_inst_pc", inst_pc, 16'h0100);

        // Flush in HOLD together with inst_ready
        flush = 1'b1; inst_ready = 1'b1;
        settle();
        check("hf_pc_adv", pc_adv, 0);
        step();
        flush = 1'b0; pc = 16'h0200;
        settle();
        check("hf_valid_drop", inst_valid, 0);
        check("hf_inst_kept", inst, 32'h5555_0005);
        check("hf_new_addr", mem_addr, 14'h0080);
        check("hf_req", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 32'h6666_0006;
        step();
        mem_ack = 1'b0;
        settle();
        check("hf_next_inst", inst, 32'h6666_0006);
        check("hf_next_pc_adv", pc_adv, 1);
        step();

        // Misaligned pc
        pc = 16'h0006; mem_ack = 1'b0;
        settle();
        check("mis_no_req", mem_req, 0);
        step();
        settle();
        check("mis_valid", inst_valid, 1);
        check("mis_fault", inst_fault, 1);
        check("mis_inst", inst, NOP);
        check("mis_inst_pc", inst_pc, 16'h0006);
        check("mis_pc_adv", pc_adv, 1);
        step();

        // Address wrap at top of memory
        pc = 16'hFFFC; mem_ack = 1'b1; mem_rdata = 32'h7777_0007;
        settle();
        check("wrap_req", mem_req, 1);
        check("wrap_addr", mem_addr, 14'h3FFF);
        step();
        mem_ack = 1'b0;
        settle();
        check("wrap_fault_clear", inst_fault, 0);
        check("wrap_inst", inst, 32'h7777_0007);
        check("wrap_inst_pc", inst_pc, 16'hFFFC);

        // Reset mid-transaction drops the request
        step();
        pc = 16'h0020; mem_ack = 1'b0;
        settle();
        check("rm_req_before", mem_req, 1);
        rst = 1'b1;
        step();
        check("rm_req_dropped", mem_req, 0);
        check("rm_valid", inst_valid, 0);
        check("rm_inst", inst, NOP);
        check("rm_mem_addr", mem_addr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
